draw_sequencer: RTL and testbench

//  Control FSM for the VGA game datapath. Takes one draw job at a time by request/ack:

---
 rtl/draw_ctrl_pkg.sv | 40 ++++
 rtl/raster_walker.sv | 69 ++++++
 rtl/draw_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// draw_ctrl_pkg
// Shared definitions for the draw sequencer: draw-mode codes, FSM state
// encoding, default raster geometry, counter widths and the latched job record.
// -----------------------------------------------------------------------------
package draw_ctrl_pkg;

  // Default raster geometry.
  localparam int SCR_W_DEF   = 160;
  localparam int SCR_H_DEF   = 120;
  localparam int SPR_DIM_DEF = 40;

  // Raster walker counter widths (col up to 159, row up to 119).
  localparam int COL_W = 8;
  localparam int ROW_W = 7;

  typedef enum logic [1:0] {
    MODE_SCREEN  = 2'b00,
    MODE_SPRITE  = 2'b01,
    MODE_CLEAR   = 2'b10,
    MODE_INVALID = 2'b11
  } draw_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PRIME = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } draw_state_e;

  // Everything captured from the requester at acknowledge time.
  typedef struct packed {
    draw_mode_e mode;
    logic [4:0] mem_sel;
    logic [4:0] x_init_sel;
    logic [1:0] y_init_sel;
  } job_t;

endpackage

// File: rtl/raster_walker.sv
// -----------------------------------------------------------------------------
// raster_walker
// Column/row position tracker for one raster pass of runtime size
// width x height. Advances one pixel per enabled cycle, wrapping col at the
// end of each row and wrapping to (0,0) after the last pixel.
//
// Ports
//   clk, resetn  clock, asynchronous active-low reset
//   clr          synchronous clear to (0,0), wins over en
//   en           advance one pixel
//   width        pixels per row   (>= 1)
//   height       rows per pass    (>= 1)
//   row_end      current pixel is the last of its row
//   last         current pixel is the last of the pass
// -----------------------------------------------------------------------------
module raster_walker
  import draw_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic             row_end,
  output logic             last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    col_d   = col_q;
    row_d   = row_q;
    row_end = (col_q == width - COL_W'(1));
    last    = row_end && (row_q == height - ROW_W'(1));

    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last) begin
        col_d = '0;
        row_d = '0;
      end else if (row_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order; the asynchronous reset
  // puts the position at (0,0) without waiting for a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
// Control FSM for the VGA game datapath. Accepts one draw job at a time via a
// request/acknowledge handshake (full-screen ROM image, square sprite, or black
// clear) and sequences the datapath strobes: origin loads, x/y counters, ROM
// address counters, colour select and the VGA plot enable.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   drawReq                     job request, sampled only in IDLE
//   drawMode                    00 screen, 01 sprite, 10 clear, 11 invalid
//   memSelIn/xInitSelIn/yInitSelIn  job parameters, latched on acknowledge
//   drawAck                     1-cycle acknowledge (inputs latched this cycle)
//   busy                        job in progress (SETUP..DONE)
//   drawDone                    1-cycle completion pulse
//   plot                        VGA write enable
//   memorySel/xInitSel/yInitSel latched job parameters
//   xInitLoad/yInitLoad         load origin registers
//   xySel                       00 origin (0,0), 01 sprite origin
//   xReset/yReset               reload x/y to origin
//   xCountUp/yCountUp           advance x/y
//   black                       force colour 000
//   addressScreenCounterReset / screenCountLoad   screen ROM address clear / +1
//   addressSpriteCounterReset / spriteCountLoad   sprite ROM address clear / +1
// -----------------------------------------------------------------------------
module draw_sequencer
  import draw_ctrl_pkg::*;
#(
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF,
  parameter int SPR_DIM = SPR_DIM_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       drawReq,
  input  logic [1:0] drawMode,
  input  logic [4:0] memSelIn,
  input  logic [4:0] xInitSelIn,
  input  logic [1:0] yInitSelIn,
  output logic       drawAck,
  output logic       busy,
  output logic       drawDone,
  output logic       plot,
  output logic [4:0] memorySel,
  output logic [4:0] xInitSel,
  output logic [1:0] yInitSel,
  output logic       xInitLoad,
  output logic       yInitLoad,
  output logic [1:0] xySel,
  output logic       xReset,
  output logic       yReset,
  output logic       xCountUp,
  output logic       yCountUp,
  output logic       black,
  output logic       addressScreenCounterReset,
  output logic       screenCountLoad,
  output logic       addressSpriteCounterReset,
  output logic       spriteCountLoad
);

  localparam int PRIME_W = $clog2(ROM_LAT + 1);

  localparam logic [COL_W-1:0]   SCR_W_L    = COL_W'(SCR_W);
  localparam logic [ROW_W-1:0]   SCR_H_L    = ROW_W'(SCR_H);
  localparam logic [COL_W-1:0]   SPR_W_L    = COL_W'(SPR_DIM);
  localparam logic [ROW_W-1:0]   SPR_H_L    = ROW_W'(SPR_DIM);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(ROM_LAT - 1);

  draw_state_e        state_q, state_d;
  job_t               job_q, job_d;
  logic [PRIME_W-1:0] prime_q, prime_d;

  logic             accept;
  logic             walk_clr, walk_en;
  logic             walk_row_end, walk_last;
  logic [COL_W-1:0] walk_w;
  logic [ROW_W-1:0] walk_h;
  logic             is_screen, is_sprite, is_clear;

  assign is_screen = (job_q.mode == MODE_SCREEN);
  assign is_sprite = (job_q.mode == MODE_SPRITE);
  assign is_clear  = (job_q.mode == MODE_CLEAR);

  // Sprite jobs walk a SPR_DIM square; screen and clear walk the full screen.
  assign walk_w = is_sprite ? SPR_W_L : SCR_W_L;
  assign walk_h = is_sprite ? SPR_H_L : SCR_H_L;

  assign memorySel = job_q.mem_sel;
  assign xInitSel  = job_q.x_init_sel;
  assign yInitSel  = job_q.y_init_sel;
  assign xySel     = is_sprite ? 2'b01 : 2'b00;
  assign busy      = (state_q != ST_IDLE);

  // Acceptance is qualified by resetn so that a request held through reset
  // cannot produce an acknowledge while the block is being reset.
  assign accept = (state_q == ST_IDLE) && drawReq && resetn;

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    prime_d  = prime_q;
    walk_clr = 1'b0;
    walk_en  = 1'b0;

    drawAck                   = 1'b0;
    drawDone                  = 1'b0;
    plot                      = 1'b0;
    xInitLoad                 = 1'b0;
    yInitLoad                 = 1'b0;
    xReset                    = 1'b0;
    yReset                    = 1'b0;
    xCountUp                  = 1'b0;
    yCountUp                  = 1'b0;
    black                     = 1'b0;
    addressScreenCounterReset = 1'b0;
    screenCountLoad           = 1'b0;
    addressSpriteCounterReset = 1'b0;
    spriteCountLoad           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          drawAck = 1'b1;
          job_d   = '{mode:       draw_mode_e'(drawMode),
                      mem_sel:    memSelIn,
                      x_init_sel: xInitSelIn,
                      y_init_sel: yInitSelIn};
          state_d = (draw_mode_e'(drawMode) == MODE_INVALID) ? ST_DONE : ST_SETUP;
        end
      end

      ST_SETUP: begin
        xInitLoad                 = 1'b1;
        yInitLoad                 = 1'b1;
        xReset                    = 1'b1;
        yReset                    = 1'b1;
        addressScreenCounterReset = 1'b1;
        addressSpriteCounterReset = 1'b1;
        walk_clr                  = 1'b1;
        prime_d                   = '0;
        // Clear has no ROM data to wait for, so it skips the prime phase.
        state_d = is_clear ? ST_DRAW : ST_PRIME;
      end

      ST_PRIME: begin
        // Run the address ahead of the pixel by ROM_LAT so the first ROM word
        // is valid on the first DRAW cycle.
        screenCountLoad = is_screen;
        spriteCountLoad = is_sprite;
        prime_d         = prime_q + PRIME_W'(1);
        if (prime_q == PRIME_LAST) begin
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
        plot            = 1'b1;
        walk_en         = 1'b1;
        black           = is_clear;
        screenCountLoad = is_screen;
        spriteCountLoad = is_sprite;
        if (walk_last) begin
          state_d = ST_DONE;
        end else if (walk_row_end) begin
          xReset   = 1'b1;
          yCountUp = 1'b1;
        end else begin
          xCountUp = 1'b1;
        end
      end

      ST_DONE: begin
        drawDone = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      prime_q <= prime_d;
    end
  end

  raster_walker u_walker (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (walk_clr),
    .en      (walk_en),
    .width   (walk_w),
    .height  (walk_h),
    .row_end (walk_row_end),
    .last    (walk_last)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_draw_sequencer
// Scoreboard bench: each issued job pushes its hand-computed expected profile
// (plot count, timing, strobe counts, latched selects) into a queue; a monitor
// counts DUT activity per job from drawAck to drawDone and compares against
// the queue head when drawDone appears.
// -----------------------------------------------------------------------------
module tb_draw_sequencer;
  import draw_ctrl_pkg::*;

  localparam int ROM_LAT = 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       drawReq;
  logic [1:0] drawMode;
  logic [4:0] memSelIn;
  logic [4:0] xInitSelIn;
  logic [1:0] yInitSelIn;
  logic       drawAck, busy, drawDone, plot;
  logic [4:0] memorySel, xInitSel;
  logic [1:0] yInitSel, xySel;
  logic       xInitLoad, yInitLoad, xReset, yReset, xCountUp, yCountUp, black;
  logic       addressScreenCounterReset, screenCountLoad;
  logic       addressSpriteCounterReset, spriteCountLoad;

  always #5 clk = ~clk;

  draw_sequencer #(
    .SCR_W   (160),
    .SCR_H   (120),
    .SPR_DIM (40),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .drawReq                   (drawReq),
    .drawMode                  (drawMode),
    .memSelIn                  (memSelIn),
    .xInitSelIn                (xInitSelIn),
    .yInitSelIn                (yInitSelIn),
    .drawAck                   (drawAck),
    .busy                      (busy),
    .drawDone                  (drawDone),
    .plot                      (plot),
    .memorySel                 (memorySel),
    .xInitSel                  (xInitSel),
    .yInitSel                  (yInitSel),
    .xInitLoad                 (xInitLoad),
    .yInitLoad                 (yInitLoad),
    .xySel                     (xySel),
    .xReset                    (xReset),
    .yReset                    (yReset),
    .xCountUp                  (xCountUp),
    .yCountUp                  (yCountUp),
    .black                     (black),
    .addressScreenCounterReset (addressScreenCounterReset),
    .screenCountLoad           (screenCountLoad),
    .addressSpriteCounterReset (addressSpriteCounterReset),
    .spriteCountLoad           (spriteCountLoad)
  );

  typedef struct {
    int         plots, first_plot, last_plot;
    int         y_ups, x_ups, x_resets;
    int         scl, spl, blacks;
    int         done_rel, busy_cyc, xysel, init_loads, ack_gap;
    logic [4:0] mem, xs;
    logic [1:0] ys;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  // Monitor statistics for the job in flight.
  bit   job_active = 0;
  int   ack_cyc, prev_done = -100;
  int   m_plots, m_first, m_last, m_yups, m_xups, m_xres, m_scl, m_spl;
  int   m_black, m_busy, m_xysel, m_loads, m_arst, m_acks, m_selbad, m_overlap;
  int   m_stray = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(draw_mode_e m, logic [4:0] mem, logic [4:0] xs,
                                    logic [1:0] ys, int gap, bit abort);
    exp_t e;
    e.mem = mem; e.xs = xs; e.ys = ys; e.ack_gap = gap; e.abort = abort;
    case (m)
      MODE_SPRITE: begin
        e.plots = 1600; e.first_plot = 3; e.last_plot = 1602;
        e.y_ups = 39; e.x_ups = 1560; e.x_resets = 40;
        e.scl = 0; e.spl = 1601; e.blacks = 0;
        e.done_rel = 1603; e.busy_cyc = 1603; e.xysel = 1; e.init_loads = 1;
      end
      MODE_SCREEN: begin
        e.plots = 19200; e.first_plot = 3; e.last_plot = 19202;
        e.y_ups = 119; e.x_ups = 19080; e.x_resets = 120;
        e.scl = 19201; e.spl = 0; e.blacks = 0;
        e.done_rel = 19203; e.busy_cyc = 19203; e.xysel = 0; e.init_loads = 1;
      end
      MODE_CLEAR: begin
        e.plots = 19200; e.first_plot = 2; e.last_plot = 19201;
        e.y_ups = 119; e.x_ups = 19080; e.x_resets = 120;
        e.scl = 0; e.spl = 0; e.blacks = 19200;
        e.done_rel = 19202; e.busy_cyc = 19202; e.xysel = 0; e.init_loads = 1;
      end
      default: begin
        e.plots = 0; e.first_plot = -1; e.last_plot = -1;
        e.y_ups = 0; e.x_ups = 0; e.x_resets = 0;
        e.scl = 0; e.spl = 0; e.blacks = 0;
        e.done_rel = 1; e.busy_cyc = 1; e.xysel = -1; e.init_loads = 0;
      end
    endcase
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t cur, e;
    int   rel;
    forever begin
      @(negedge clk or negedge resetn);
      if (!resetn) begin
        if (job_active) begin
          job_active = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("abort_expected", e.abort, 1);
          end
        end
      end else begin
        if (drawAck) begin
          if (!job_active) begin
            if (exp_q.size() == 0) begin
              check("unexpected_ack", exp_q.size(), 1);
            end else begin
              cur = exp_q[0];
              job_active = 1;
              ack_cyc = cyc;
              m_plots = 0; m_first = -1; m_last = -1; m_yups = 0; m_xups = 0;
              m_xres = 0; m_scl = 0; m_spl = 0; m_black = 0; m_busy = 0;
              m_xysel = -1; m_loads = 0; m_arst = 0; m_acks = 0; m_selbad = 0;
              m_overlap = 0;
              if (cur.ack_gap >= 0) check("ack_gap", cyc - prev_done, cur.ack_gap);
            end
          end
          m_acks++;
        end
        if (job_active) begin
          rel = cyc - ack_cyc;
          if (plot) begin
            m_plots++;
            if (m_first < 0) m_first = rel;
            m_last = rel;
          end
          if (yCountUp)                  m_yups++;
          if (xCountUp)                  m_xups++;
          if (xReset)                    m_xres++;
          if (screenCountLoad)           m_scl++;
          if (spriteCountLoad)           m_spl++;
          if (black)                     m_black++;
          if (busy)                      m_busy++;
          if (addressScreenCounterReset && addressSpriteCounterReset) m_arst++;
          if (xCountUp && xReset)        m_overlap++;
          if (xInitLoad && yInitLoad) begin
            m_loads++;
            m_xysel = int'(xySel);
          end
          if (rel >= 1 && {memorySel, xInitSel, yInitSel} != {cur.mem, cur.xs, cur.ys})
            m_selbad++;
          if (drawDone) begin
            e = exp_q.pop_front();
            check("abort_not_expected", e.abort, 0);
            check("plots",        m_plots,   e.plots);
            check("first_plot",   m_first,   e.first_plot);
            check("last_plot",    m_last,    e.last_plot);
            check("y_count_ups",  m_yups,    e.y_ups);
            check("x_count_ups",  m_xups,    e.x_ups);
            check("x_resets",     m_xres,    e.x_resets);
            check("screen_loads", m_scl,     e.scl);
            check("sprite_loads", m_spl,     e.spl);
            check("black_cycles", m_black,   e.blacks);
            check("done_cycle",   rel,       e.done_rel);
            check("busy_cycles",  m_busy,    e.busy_cyc);
            check("xy_sel",       m_xysel,   e.xysel);
            check("init_loads",   m_loads,   e.init_loads);
            check("addr_resets",  m_arst,    e.init_loads);
            check("acks_per_job", m_acks,    1);
            check("sel_held",     m_selbad,  0);
            check("x_overlap",    m_overlap, 0);
            job_active = 0;
            prev_done = cyc;
            done_cnt++;
          end
        end else begin
          if (drawDone) check("unexpected_done", job_active, 1);
          if (plot || busy || xCountUp || yCountUp || screenCountLoad || spriteCountLoad)
            m_stray++;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    logic [31:0] outs;
    outs = {drawAck, busy, drawDone, plot, memorySel, xInitSel, yInitSel,
            xInitLoad, yInitLoad, xySel, xReset, yReset, xCountUp, yCountUp,
            black, addressScreenCounterReset, screenCountLoad,
            addressSpriteCounterReset, spriteCountLoad};
    check({tag, "_outputs"}, outs, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic start_job(input draw_mode_e m, input logic [4:0] mem,
                           input logic [4:0] xs, input logic [1:0] ys, input bit abort);
    bit got;
    exp_q.push_back(make_exp(m, mem, xs, ys, -1, abort));
    @(posedge clk); #1;
    drawReq = 1'b1; drawMode = m; memSelIn = mem; xInitSelIn = xs; yInitSelIn = ys;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = drawAck;
    end
    check("ack_seen", got, 1);
    @(posedge clk); #1;
    // Scramble inputs: the job must run from the latched copies.
    drawReq = 1'b0; drawMode = 2'b10;
    memSelIn = ~mem; xInitSelIn = ~xs; yInitSelIn = ~ys;
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("done_reached", done_cnt, target);
  endtask

  initial begin
    int i;
    resetn = 1'b0; drawReq = 1'b1; drawMode = 2'b01;
    memSelIn = 5'd3; xInitSelIn = 5'd3; yInitSelIn = 2'd1;
    #2;
    check_all_zero("reset_init");
    drawReq = 1'b0;
    #10 resetn = 1'b1;

    // Sprite, origin select 3.
    start_job(MODE_SPRITE, 5'd7, 5'd3, 2'd2, 0);
    wait_done(1, 1700);

    // Full screen image 5.
    start_job(MODE_SCREEN, 5'd5, 5'd0, 2'd0, 0);
    wait_done(2, 19300);

    // Black clear.
    start_job(MODE_CLEAR, 5'd9, 5'd0, 2'd0, 0);
    wait_done(3, 19300);

    // Invalid mode: straight to DONE, no plots.
    start_job(MODE_INVALID, 5'd1, 5'd2, 2'd3, 0);
    wait_done(4, 20);

    // Reset in the middle of a sprite, at DRAW pixel 500.
    start_job(MODE_SPRITE, 5'd11, 5'd6, 2'd1, 1);
    i = 0;
    while (m_plots < 500 && i < 2000) begin
      @(posedge clk);
      i++;
    end
    check("reached_pixel_500", m_plots, 500);
    #2 resetn = 1'b0;
    #1 check_all_zero("reset_mid_draw");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_held");
    resetn = 1'b1;

    // New job after release restarts cleanly from SETUP.
    start_job(MODE_SPRITE, 5'd12, 5'd17, 2'd1, 0);
    wait_done(5, 1700);

    // Request held across two jobs: one ack per IDLE entry, the second
    // taken the cycle after DONE.
    exp_q.push_back(make_exp(MODE_SPRITE, 5'd20, 5'd30, 2'd3, -1, 0));
    exp_q.push_back(make_exp(MODE_SPRITE, 5'd20, 5'd30, 2'd3, 1, 0));
    @(posedge clk); #1;
    drawReq = 1'b1; drawMode = 2'b01; memSelIn = 5'd20; xInitSelIn = 5'd30; yInitSelIn = 2'd3;
    wait_done(6, 1700);
    wait_done(7, 1700);
    drawReq = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    check("stray_activity", m_stray, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
